// File: rtl/impact_detector.sv
// Two-channel accelerometer impact detector: L1 magnitude, N-hit streak, valid/ready record, hold-off.
// Optional macro IMPACT_TIMESTAMP_EN captures a free-running cycle counter into evt_time.

module impact_mag_lane #(
    parameter logic [17:0] THRESH = 18'd24000,
    parameter int          HITS   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_run,
    input  logic        i_valid,
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    input  logic [15:0] i_z,
    output logic [17:0] o_mag,
    output logic        o_reach
);
    localparam logic [3:0] HITS4 = 4'(HITS);

    logic [16:0] r_ax, r_ay, r_az;
    logic        r_v1, r_v2, r_hit;
    logic [17:0] r_mag, w_sum;
    logic [3:0]  r_streak, w_streak_nx;

    // 17-bit result so that abs(-32768) = 32768 is representable
    function automatic logic [16:0] abs17(input logic [15:0] v);
        logic [16:0] e;
        e = {v[15], v};
        return v[15] ? (~e + 17'd1) : e;
    endfunction

    assign w_sum = 18'(r_ax) + 18'(r_ay) + 18'(r_az);

    always_comb begin
        w_streak_nx = r_streak;
        if (r_v2) begin
            if (!r_hit)
                w_streak_nx = 4'd0;
            else if (r_streak >= HITS4)
                w_streak_nx = HITS4;
            else
                w_streak_nx = r_streak + 4'd1;
        end
    end

    // i_run low clears the in-flight valids and the streak so re-arm needs a fresh run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_ax     <= '0;
            r_ay     <= '0;
            r_az     <= '0;
            r_mag    <= '0;
            r_hit    <= 1'b0;
            r_streak <= '0;
        end else begin
            r_v1 <= i_valid & i_run;
            r_v2 <= r_v1 & i_run;
            if (i_valid) begin
                r_ax <= abs17(i_x);
                r_ay <= abs17(i_y);
                r_az <= abs17(i_z);
            end
            if (r_v1) begin
                r_mag <= w_sum;
                r_hit <= (w_sum > THRESH);
            end
            r_streak <= i_run ? w_streak_nx : 4'd0;
        end
    end

    assign o_mag   = r_mag;
    assign o_reach = r_v2 & r_hit & (w_streak_nx == HITS4);
endmodule

module impact_detector #(
    parameter logic [17:0] THRESH  = 18'd24000,
    parameter int          HITS    = 3,
    parameter int          HOLDOFF = 100000000
) (
    input  logic        clk,
    input  logic        reset_top_n,
    input  logic        s0_valid,
    input  logic [15:0] s0_x,
    input  logic [15:0] s0_y,
    input  logic [15:0] s0_z,
    input  logic        s1_valid,
    input  logic [15:0] s1_x,
    input  logic [15:0] s1_y,
    input  logic [15:0] s1_z,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [1:0]  evt_src,
    output logic [17:0] evt_peak,
    output logic [7:0]  evt_count,
    output logic [31:0] evt_time,
    output logic        armed
);
    localparam int NCH = 2;
    localparam int HW  = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF - 1);

    typedef enum logic [1:0] {ST_ARMED, ST_REPORT, ST_HOLDOFF} state_t;

    state_t                     r_state, w_state_nx;
    logic [NCH-1:0]             w_vld, w_reach;
    logic [NCH-1:0][15:0]       w_x, w_y, w_z;
    logic [NCH-1:0][17:0]       w_mag;
    logic [17:0]                w_m0, w_m1, w_peak;
    logic                       w_trig, w_run, w_hold_load;
    logic [HW-1:0]              r_hold;
    logic [1:0]                 r_src;
    logic [17:0]                r_peak;
    logic [7:0]                 r_count;

    assign w_vld = {s1_valid, s0_valid};
    assign w_x   = {s1_x, s0_x};
    assign w_y   = {s1_y, s0_y};
    assign w_z   = {s1_z, s0_z};

    for (genvar g = 0; g < NCH; g++) begin : g_lane
        impact_mag_lane #(.THRESH(THRESH), .HITS(HITS)) u_lane (
            .clk     (clk),
            .rst_n   (reset_top_n),
            .i_run   (w_run),
            .i_valid (w_vld[g]),
            .i_x     (w_x[g]),
            .i_y     (w_y[g]),
            .i_z     (w_z[g]),
            .o_mag   (w_mag[g]),
            .o_reach (w_reach[g])
        );
    end

    assign w_trig = (r_state == ST_ARMED) & (|w_reach);
    assign w_run  = (r_state == ST_ARMED) & ~w_trig;

    always_comb begin
        w_m0   = w_reach[0] ? w_mag[0] : 18'd0;
        w_m1   = w_reach[1] ? w_mag[1] : 18'd0;
        w_peak = (w_m1 > w_m0) ? w_m1 : w_m0;
    end

    always_ff @(posedge clk or negedge reset_top_n) begin
        if (!reset_top_n)
            r_state <= ST_ARMED;
        else
            r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx  = r_state;
        w_hold_load = 1'b0;
        evt_valid   = 1'b0;
        armed       = 1'b0;
        case (r_state)
            ST_ARMED: begin
                armed = 1'b1;
                if (w_trig) w_state_nx = ST_REPORT;
            end
            ST_REPORT: begin
                evt_valid = 1'b1;
                if (evt_ready) begin
                    w_hold_load = 1'b1;
                    w_state_nx  = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (r_hold == '0) w_state_nx = ST_ARMED;
            end
            default: w_state_nx = ST_ARMED;
        endcase
    end

    always_ff @(posedge clk or negedge reset_top_n) begin
        if (!reset_top_n) begin
            r_hold  <= '0;
            r_src   <= '0;
            r_peak  <= '0;
            r_count <= '0;
        end else begin
            if (w_hold_load)
                r_hold <= HOLD_LOAD;
            else if (r_state == ST_HOLDOFF && r_hold != '0)
                r_hold <= r_hold - HW'(1);
            if (w_trig) begin
                r_src   <= w_reach;
                r_peak  <= w_peak;
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign evt_src   = r_src;
    assign evt_peak  = r_peak;
    assign evt_count = r_count;

`ifdef IMPACT_TIMESTAMP_EN
    logic [31:0] r_cyc, r_time;

    always_ff @(posedge clk or negedge reset_top_n) begin
        if (!reset_top_n) begin
            r_cyc  <= '0;
            r_time <= '0;
        end else begin
            r_cyc <= r_cyc + 32'd1;
            if (w_trig) r_time <= r_cyc;
        end
    end

    assign evt_time = r_time;
`else
    assign evt_time = 32'd0;
`endif
endmodule

// File: tb/tb_impact_detector.sv
// Directed table-driven bench for impact_detector (HITS=3, HOLDOFF=20) plus async-reset sequences.
module tb_impact_detector;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        s0_valid, s1_valid, evt_ready;
    logic [15:0] s0_x, s0_y, s0_z, s1_x, s1_y, s1_z;
    logic        evt_valid, armed;
    logic [1:0]  evt_src;
    logic [17:0] evt_peak;
    logic [7:0]  evt_count;
    logic [31:0] evt_time;

    impact_detector #(.THRESH(18'd24000), .HITS(3), .HOLDOFF(20)) dut (
        .clk(clk), .reset_top_n(rst_n),
        .s0_valid(s0_valid), .s0_x(s0_x), .s0_y(s0_y), .s0_z(s0_z),
        .s1_valid(s1_valid), .s1_x(s1_x), .s1_y(s1_y), .s1_z(s1_z),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_src(evt_src),
        .evt_peak(evt_peak), .evt_count(evt_count), .evt_time(evt_time), .armed(armed)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [15:0] x, y, z;
    } samp_t;

    localparam samp_t IDL = '{1'b0, 16'd0, 16'd0, 16'd0};
    localparam samp_t H25 = '{1'b1, 16'd10000, 16'd10000, 16'd5000};       // 25000
    localparam samp_t EQ  = '{1'b1, 16'd10000, 16'd10000, 16'd4000};       // 24000
    localparam samp_t H30 = '{1'b1, 16'd10000, 16'd10000, 16'd10000};      // 30000
    localparam samp_t H40 = '{1'b1, 16'd20000, 16'hD8F0, 16'd10000};       // 20000,-10000,10000
    localparam samp_t MXN = '{1'b1, 16'h8000, 16'h8000, 16'h8000};         // 98304

    typedef struct {
        samp_t       a, b;
        logic        rdy;
        int          rep;
        logic        ev, arm;
        int          cnt;
        logic [1:0]  src;
        int          peak;
    } row_t;

    row_t tbl[$];
    int   n_chk = 0, n_fail = 0, cur_row = 0;
    logic prev_ev = 1'b0;
    logic [31:0] exp_time = 32'd0;
    logic [31:0] tb_cyc;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) tb_cyc <= 32'd0;
        else        tb_cyc <= tb_cyc + 32'd1;

    function automatic void add(input samp_t a, input samp_t b, input logic rdy, input int rep,
                                input logic ev, input logic arm, input int cnt,
                                input logic [1:0] src, input int peak);
        row_t r;
        r.a = a; r.b = b; r.rdy = rdy; r.rep = rep; r.ev = ev; r.arm = arm;
        r.cnt = cnt; r.src = src; r.peak = peak;
        tbl.push_back(r);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (row %0d, t=%0t): got %0d, expected %0d", nm, cur_row, $time, act, exp);
        end
    endtask

    task automatic drive(input samp_t a, input samp_t b, input logic rdy);
        s0_valid = a.v; s0_x = a.x; s0_y = a.y; s0_z = a.z;
        s1_valid = b.v; s1_x = b.x; s1_y = b.y; s1_z = b.z;
        evt_ready = rdy;
    endtask

    task automatic step(input samp_t a, input samp_t b, input logic rdy);
        drive(a, b, rdy);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(IDL, IDL, 1'b0);

        // ch0 trigger, ready low for two report cycles, hold-off of exactly 20 cycles
        add(H25, IDL, 0, 3,  0, 1, 0, 2'b00, 0);
        add(IDL, IDL, 0, 1,  0, 1, 0, 2'b00, 0);
        add(IDL, IDL, 0, 2,  1, 0, 1, 2'b01, 25000);
        add(IDL, IDL, 1, 1,  0, 0, 1, 2'b00, 0);
        add(IDL, IDL, 0, 19, 0, 0, 1, 2'b00, 0);
        add(IDL, IDL, 0, 1,  0, 1, 1, 2'b00, 0);
        // mag == THRESH breaks the streak; the run restarts from 1
        add(H25, IDL, 0, 2,  0, 1, 1, 2'b00, 0);
        add(EQ,  IDL, 0, 1,  0, 1, 1, 2'b00, 0);
        add(H25, IDL, 0, 1,  0, 1, 1, 2'b00, 0);
        add(IDL, IDL, 0, 2,  0, 1, 1, 2'b00, 0);
        add(H25, IDL, 0, 1,  0, 1, 1, 2'b00, 0);
        add(IDL, IDL, 0, 2,  0, 1, 1, 2'b00, 0);
        add(H25, IDL, 0, 1,  0, 1, 1, 2'b00, 0);
        add(IDL, IDL, 0, 1,  0, 1, 1, 2'b00, 0);
        add(IDL, IDL, 1, 1,  1, 0, 2, 2'b01, 25000);   // ready already high at trigger
        add(IDL, IDL, 1, 1,  0, 0, 2, 2'b00, 0);
        add(IDL, IDL, 0, 19, 0, 0, 2, 2'b00, 0);
        add(IDL, IDL, 0, 1,  0, 1, 2, 2'b00, 0);
        // both channels on the same cycle
        add(H30, H40, 0, 3,  0, 1, 2, 2'b00, 0);
        add(IDL, IDL, 0, 1,  0, 1, 2, 2'b00, 0);
        add(IDL, IDL, 0, 1,  1, 0, 3, 2'b11, 40000);
        add(IDL, IDL, 1, 1,  0, 0, 3, 2'b00, 0);
        add(IDL, IDL, 0, 19, 0, 0, 3, 2'b00, 0);
        add(IDL, IDL, 0, 1,  0, 1, 3, 2'b00, 0);
        // ch1 full-scale negative, no wrap
        add(IDL, MXN, 0, 3,  0, 1, 3, 2'b00, 0);
        add(IDL, IDL, 0, 1,  0, 1, 3, 2'b00, 0);
        add(IDL, IDL, 0, 1,  1, 0, 4, 2'b10, 98304);
        add(IDL, IDL, 1, 1,  0, 0, 4, 2'b00, 0);
        add(IDL, IDL, 0, 19, 0, 0, 4, 2'b00, 0);
        add(IDL, IDL, 0, 1,  0, 1, 4, 2'b00, 0);
        // hits keep coming through a 50-cycle stall and the whole hold-off
        add(H25, IDL, 0, 3,  0, 1, 4, 2'b00, 0);
        add(H25, IDL, 0, 1,  0, 1, 4, 2'b00, 0);
        add(H25, IDL, 0, 51, 1, 0, 5, 2'b01, 25000);
        add(H25, IDL, 1, 1,  0, 0, 5, 2'b00, 0);
        add(H25, IDL, 0, 19, 0, 0, 5, 2'b00, 0);
        add(H25, IDL, 0, 1,  0, 1, 5, 2'b00, 0);
        add(H25, IDL, 0, 3,  0, 1, 5, 2'b00, 0);
        add(IDL, IDL, 0, 1,  0, 1, 5, 2'b00, 0);
        add(IDL, IDL, 0, 1,  1, 0, 6, 2'b01, 25000);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_evt_valid", 32'(evt_valid), 32'd0);
        chk("rst_armed",     32'(armed),     32'd1);
        chk("rst_evt_count", 32'(evt_count), 32'd0);
        chk("rst_evt_src",   32'(evt_src),   32'd0);
        chk("rst_evt_peak",  32'(evt_peak),  32'd0);
        chk("rst_evt_time",  evt_time,       32'd0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            cur_row = i;
            for (int k = 0; k < tbl[i].rep; k++) begin
                step(tbl[i].a, tbl[i].b, tbl[i].rdy);
`ifdef IMPACT_TIMESTAMP_EN
                if (tbl[i].ev && !prev_ev) exp_time = tb_cyc - 32'd1;
`endif
                prev_ev = tbl[i].ev;
                chk("evt_valid", 32'(evt_valid), 32'(tbl[i].ev));
                chk("armed",     32'(armed),     32'(tbl[i].arm));
                chk("evt_count", 32'(evt_count), 32'(tbl[i].cnt));
                if (tbl[i].ev) begin
                    chk("evt_src",  32'(evt_src),  32'(tbl[i].src));
                    chk("evt_peak", 32'(evt_peak), 32'(tbl[i].peak));
                    chk("evt_time", evt_time,      exp_time);
                end
            end
        end

        // async reset in REPORT drops the record and clears the count
        cur_row = -1;
        drive(IDL, IDL, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("rpt_rst_evt_valid", 32'(evt_valid), 32'd0);
        chk("rpt_rst_evt_count", 32'(evt_count), 32'd0);
        chk("rpt_rst_armed",     32'(armed),     32'd1);
        chk("rpt_rst_evt_src",   32'(evt_src),   32'd0);
        chk("rpt_rst_evt_peak",  32'(evt_peak),  32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 3; k++) step(H25, IDL, 1'b0);
        step(IDL, IDL, 1'b0);
        chk("post_rst_no_early", 32'(evt_valid), 32'd0);
        step(IDL, IDL, 1'b0);
        chk("post_rst_evt_valid", 32'(evt_valid), 32'd1);
        chk("post_rst_evt_count", 32'(evt_count), 32'd1);
        chk("post_rst_evt_src",   32'(evt_src),   32'd1);

        // async reset in HOLDOFF re-arms immediately
        step(IDL, IDL, 1'b1);
        step(IDL, IDL, 1'b0);
        step(IDL, IDL, 1'b0);
        chk("hold_armed", 32'(armed), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("hold_rst_armed",     32'(armed),     32'd1);
        chk("hold_rst_evt_count", 32'(evt_count), 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        step(IDL, IDL, 1'b0);
        chk("hold_rst_stays_armed", 32'(armed), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
